// File: rtl/garage_fsm_pkg.sv
// Shared state encoding and helpers for the garage-door motor controller.
package garage_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MOVE_UP = 2'b01,
    MOVE_DN = 2'b10
  } state_e;

  // Both limit switches closed cannot happen on a healthy door.
  function automatic logic limits_fault(input logic up_max, input logic dn_max);
    return up_max & dn_max;
  endfunction

endpackage

// File: rtl/garage_fsm_if.sv
// Door-side sensor/command inputs and motor-enable outputs of the controller.
interface garage_fsm_if;
  logic Up_Max;
  logic Dn_Max;
  logic Active;
  logic UP_M;
  logic DN_M;

  modport master (output Up_Max, output Dn_Max, output Active,
                  input  UP_M,   input  DN_M);
  modport slave  (input  Up_Max, input  Dn_Max, input  Active,
                  output UP_M,   output DN_M);
endinterface

// File: rtl/garage_fsm.sv
// Three-state Moore controller: starts the motor on Active, stops it at the
// limit switch in the direction of travel; both limits closed forces IDLE.
module garage_fsm
  import garage_fsm_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  garage_fsm_if.slave  bus
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (!limits_fault(bus.Up_Max, bus.Dn_Max)) begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
          if (bus.Active) begin
            // Closed or mid-travel opens; fully open closes.
            if (bus.Up_Max) state_d = MOVE_DN;
            else            state_d = MOVE_UP;
          end
        end
        MOVE_UP: state_d = bus.Up_Max ? IDLE : MOVE_UP;
        MOVE_DN: state_d = bus.Dn_Max ? IDLE : MOVE_DN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.UP_M = 1'b0;
    bus.DN_M = 1'b0;
    case (state_q)
      MOVE_UP: bus.UP_M = 1'b1;
      MOVE_DN: bus.DN_M = 1'b1;
      default: ;
    endcase
  end

  a_excl: assert property (@(posedge clk) disable iff (!reset_n)
                           !(bus.UP_M && bus.DN_M));
  a_rst_off: assert property (@(posedge clk)
                              !reset_n |-> (!bus.UP_M && !bus.DN_M));

endmodule

// File: tb/tb_garage_fsm.sv
// Directed self-checking bench for garage_fsm; expectations are hand-derived.
module tb_garage_fsm;

  logic clk = 1'b0;
  logic reset_n;
  int unsigned n_run = 0;
  int unsigned n_fail = 0;

  garage_fsm_if bus ();

  garage_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: {UP_M,DN_M} got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] outs();
    return {bus.UP_M, bus.DN_M};
  endfunction

  initial begin
    // Reset held with an open request present
    reset_n    = 1'b0;
    bus.Active = 1'b1;
    bus.Dn_Max = 1'b1;
    bus.Up_Max = 1'b0;
    #3 check("rst_noclk", outs(), 2'b00);
    tick();
    check("rst_edge", outs(), 2'b00);
    #2 reset_n = 1'b1;
    tick();
    check("rst_release_up", outs(), 2'b10);

    // Open: travel then stop at upper limit
    bus.Dn_Max = 1'b0;
    bus.Active = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("open_hold", outs(), 2'b10);
    end
    bus.Up_Max = 1'b1;
    #2 check("open_stop_not_comb", outs(), 2'b10);
    tick();
    check("open_stop", outs(), 2'b00);

    // Close: travel then stop at lower limit
    bus.Active = 1'b1;
    tick();
    check("close_start", outs(), 2'b01);
    bus.Up_Max = 1'b0;
    bus.Active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("close_hold", outs(), 2'b01);
    end
    bus.Dn_Max = 1'b1;
    tick();
    check("close_stop", outs(), 2'b00);

    // Idle hold across all limit combinations without a request
    bus.Active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {bus.Up_Max, bus.Dn_Max} = 2'(i);
      tick();
      check("idle_hold", outs(), 2'b00);
    end

    // Request glitch between edges is not sampled
    bus.Up_Max = 1'b0;
    bus.Dn_Max = 1'b0;
    #1 bus.Active = 1'b1;
    #2 bus.Active = 1'b0;
    tick();
    check("glitch_ignored", outs(), 2'b00);

    // Mid-travel request opens
    bus.Active = 1'b1;
    tick();
    check("midtravel_up", outs(), 2'b10);

    // Fault: both limits force IDLE and hold it despite Active
    bus.Up_Max = 1'b1;
    bus.Dn_Max = 1'b1;
    tick();
    check("fault_stop", outs(), 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fault_hold", outs(), 2'b00);
    end

    // Active ignored while moving down
    bus.Dn_Max = 1'b0;
    tick();
    check("dn_start", outs(), 2'b01);
    bus.Up_Max = 1'b0;
    bus.Active = 1'b1;
    tick();
    check("dn_active_ignored", outs(), 2'b01);

    // Asynchronous reset mid-motion
    bus.Active = 1'b0;
    #1 reset_n = 1'b0;
    #1 check("rst_async", outs(), 2'b00);
    #2 reset_n = 1'b1;
    tick();
    check("rst_async_idle", outs(), 2'b00);
    tick();
    check("rst_async_idle2", outs(), 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/garage_fsm.md
# garage_fsm

Controller for a garage-door motor: a three-state Moore FSM that starts the motor on an `Active` request and stops it when the travel limit switch in the direction of motion closes. It sits between the door's limit-switch and push-button inputs and the motor driver. Inputs arrive synchronised to `clk`. Outputs are registered-state decodes driving the up/down motor enables.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset; one clock domain
- `Up_Max`  in  1  high when the door is fully open (upper limit switch)
- `Dn_Max`  in  1  high when the door is fully closed (lower limit switch)
- `Active`  in  1  operate request (button/remote), level-sensitive
- `UP_M`  out  1  drive motor upward (open)
- `DN_M`  out  1  drive motor downward (close)

## Operation
- States: IDLE, MOVE_UP, MOVE_DN. The encoding is 2-bit binary; the unused code recovers to IDLE.
- IDLE:
  - Active=1, Dn_Max=1, Up_Max=0 -> MOVE_UP.
  - Active=1, Up_Max=1, Dn_Max=0 -> MOVE_DN.
  - Active=1 with the door mid-travel (both limits 0) -> MOVE_UP.
  - Otherwise stay in IDLE.
- MOVE_UP: Up_Max=1 -> IDLE; otherwise stay. Active is ignored while moving.
- MOVE_DN: Dn_Max=1 -> IDLE; otherwise stay. Active is ignored while moving.
- Both limits high is a fault condition:
  - From any state, go to or stay in IDLE.
  - This takes priority over all other transitions.
- Outputs are Moore decodes of the current state:
  - UP_M=1 only in MOVE_UP.
  - DN_M=1 only in MOVE_DN.
  - UP_M and DN_M are never both 1.

## Timing
- Reset: asserting reset_n=0 forces IDLE immediately, without a clock. UP_M=0 and DN_M=0 while reset is held.
- Reset mid-motion stops the motor asynchronously.
- After reset is released, the first transition occurs on the next rising edge at which the transition conditions hold.
- Latency: an input change is sampled on the next rising edge. Outputs change after that edge (clock-to-q plus decode). There is no combinational input-to-output path.
- A limit switch reaching its maximum stops the motor one edge later. The stop is not combinational.
- Inputs are sampled only on clock edges. Glitches between edges have no effect.

## Structure
- Shared package: state enum/localparams (`IDLE`, `MOVE_UP`, `MOVE_DN`).
- Single module, no sub-modules:
  - one sequential block for the state register with asynchronous reset;
  - one combinational next-state block, which defaults to IDLE;
  - one output decode block.
- Optional assertions:
  - `!(UP_M && DN_M)` at all times;
  - outputs are 0 while `!reset_n`.

## Test plan
- Reset: drive reset_n=0 for 1 cycle with Active=1, Dn_Max=1. Expect UP_M=0, DN_M=0 during reset, with no clock edge needed. Release reset; UP_M=1 after the first rising edge.
- Open: from IDLE with Active=1, Dn_Max=1, Up_Max=0. After one edge, UP_M=1 and DN_M=0. Set Dn_Max=0 and Active=0 and hold 5 cycles; UP_M stays 1. Set Up_Max=1; after one edge, UP_M=0 and DN_M=0.
- Close: from IDLE with Active=1, Up_Max=1, Dn_Max=0. After one edge, DN_M=1 and UP_M=0. Set Up_Max=0 and Active=0 and hold 3 cycles; DN_M stays 1. Set Dn_Max=1; after one edge, both outputs are 0.
- Idle hold: with Active=0, cycle through all limit combinations for 4 cycles. Both outputs stay 0. With Active=1 and Up_Max=Dn_Max=0 from IDLE, UP_M=1 after one edge.
- Fault: in MOVE_UP, drive Up_Max=Dn_Max=1. Both outputs are 0 after one edge. Hold Active=1; the FSM stays in IDLE.
- Reset mid-motion: in MOVE_DN, pulse reset_n low for 3 ns between edges. DN_M=0 immediately and the FSM stays in IDLE.
